// File: rtl/soc_ram.sv
// soc_ram: dual-region word memory for the hxd32 SoC.
// IRAM lives at region 0x0, DRAM at region 0x1 (addr[31:28]).
// Two asynchronous CPU read ports, one shared write port owned either by the
// CPU data path or by the byte-wide host loader, and a registered host read.
module soc_ram #(
  parameter int XLEN = 32,
  parameter int I_AW = 10,
  parameter int D_AW = 10
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            ram_rw_sel_i,
  input  logic [XLEN-1:0] ram_rw_addr_i,
  input  logic [XLEN-1:0] ram_wr_data_i,
  input  logic [3:0]      ram_wr_byte_en_i,
  input  logic [XLEN-1:0] iram_rd_addr_i,
  input  logic [XLEN-1:0] dram_rd_addr_i,
  input  logic [XLEN-1:0] dram_wr_addr_i,
  input  logic [XLEN-1:0] dram_wr_data_i,
  input  logic [3:0]      dram_wr_byte_en_i,
  output logic [XLEN-1:0] iram_rd_data_o,
  output logic [XLEN-1:0] dram_rd_data_o,
  output logic [7:0]      ram_rd_data_o
);

  localparam logic [3:0] REGION_IRAM = 4'h0;
  localparam logic [3:0] REGION_DRAM = 4'h1;

  // Storage; contents are deliberately not touched by reset.
  logic [XLEN-1:0] r_iram [0:(1<<I_AW)-1];
  logic [XLEN-1:0] r_dram [0:(1<<D_AW)-1];

  logic [7:0]      r_ram_rd_data;

  logic [XLEN-1:0] w_wr_addr;
  logic [XLEN-1:0] w_wr_data;
  logic [3:0]      w_wr_be;
  logic            w_wr_iram;
  logic            w_wr_dram;
  logic [XLEN-1:0] w_host_word;
  logic [XLEN-1:0] w_iram_rd_word;
  logic [XLEN-1:0] w_dram_rd_word;

  // Decoded word read of either region; unmapped regions read as zero.
  function automatic logic [XLEN-1:0] rd_word(input logic [XLEN-1:0] addr);
    logic [XLEN-1:0] word;
    case (addr[31:28])
      REGION_IRAM: word = r_iram[addr[I_AW+1:2]];
      REGION_DRAM: word = r_dram[addr[D_AW+1:2]];
      default:     word = {XLEN{1'b0}};
    endcase
    return word;
  endfunction

  // Select one byte lane of a word.
  function automatic logic [7:0] pick_byte(input logic [XLEN-1:0] word,
                                           input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Ownership mux: exactly one requester drives the shared write port.
  always_comb begin
    w_wr_addr = dram_wr_addr_i;
    w_wr_data = dram_wr_data_i;
    w_wr_be   = dram_wr_byte_en_i;
    if (ram_rw_sel_i) begin
      w_wr_addr = ram_rw_addr_i;
      w_wr_data = ram_wr_data_i;
      w_wr_be   = ram_wr_byte_en_i;
    end else begin
      w_wr_addr = dram_wr_addr_i;
      w_wr_data = dram_wr_data_i;
      w_wr_be   = dram_wr_byte_en_i;
    end
  end

  // Region write strobes; writes are suppressed while reset is asserted.
  always_comb begin
    w_wr_iram = 1'b0;
    w_wr_dram = 1'b0;
    if (rst_n_i && (w_wr_be != 4'h0)) begin
      w_wr_iram = (w_wr_addr[31:28] == REGION_IRAM);
      w_wr_dram = (w_wr_addr[31:28] == REGION_DRAM);
    end else begin
      w_wr_iram = 1'b0;
      w_wr_dram = 1'b0;
    end
  end

  // Asynchronous read ports (both decode both regions).
  always_comb begin
    w_iram_rd_word = rd_word(iram_rd_addr_i);
    w_dram_rd_word = rd_word(dram_rd_addr_i);
    w_host_word    = rd_word(ram_rw_addr_i);
  end

  // IRAM byte-lane write.
  always_ff @(posedge clk_i) begin
    if (w_wr_iram) begin
      for (int b = 0; b < 4; b++) begin
        if (w_wr_be[b]) begin
          r_iram[w_wr_addr[I_AW+1:2]][8*b +: 8] <= w_wr_data[8*b +: 8];
        end
      end
    end
  end

  // DRAM byte-lane write.
  always_ff @(posedge clk_i) begin
    if (w_wr_dram) begin
      for (int b = 0; b < 4; b++) begin
        if (w_wr_be[b]) begin
          r_dram[w_wr_addr[D_AW+1:2]][8*b +: 8] <= w_wr_data[8*b +: 8];
        end
      end
    end
  end

  // Registered host byte read; samples the pre-write word (read-before-write).
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_ram_rd_data <= 8'h00;
    end else begin
      r_ram_rd_data <= pick_byte(w_host_word, ram_rw_addr_i[1:0]);
    end
  end

  assign iram_rd_data_o = w_iram_rd_word;
  assign dram_rd_data_o = w_dram_rd_word;
  assign ram_rd_data_o  = r_ram_rd_data;

endmodule

// File: tb/tb_soc_ram.sv
// Directed self-checking bench for soc_ram.
module tb_soc_ram;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        ram_rw_sel_i;
  logic [31:0] ram_rw_addr_i;
  logic [31:0] ram_wr_data_i;
  logic [3:0]  ram_wr_byte_en_i;
  logic [31:0] iram_rd_addr_i;
  logic [31:0] dram_rd_addr_i;
  logic [31:0] dram_wr_addr_i;
  logic [31:0] dram_wr_data_i;
  logic [3:0]  dram_wr_byte_en_i;
  logic [31:0] iram_rd_data_o;
  logic [31:0] dram_rd_data_o;
  logic [7:0]  ram_rd_data_o;

  int n_total = 0;
  int n_bad   = 0;

  soc_ram #(.XLEN(32), .I_AW(10), .D_AW(10)) dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .ram_rw_sel_i     (ram_rw_sel_i),
    .ram_rw_addr_i    (ram_rw_addr_i),
    .ram_wr_data_i    (ram_wr_data_i),
    .ram_wr_byte_en_i (ram_wr_byte_en_i),
    .iram_rd_addr_i   (iram_rd_addr_i),
    .dram_rd_addr_i   (dram_rd_addr_i),
    .dram_wr_addr_i   (dram_wr_addr_i),
    .dram_wr_data_i   (dram_wr_data_i),
    .dram_wr_byte_en_i(dram_wr_byte_en_i),
    .iram_rd_data_o   (iram_rd_data_o),
    .dram_rd_data_o   (dram_rd_data_o),
    .ram_rd_data_o    (ram_rd_data_o)
  );

  // 10 ns clock.
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic host_wr(input logic [31:0] a, input logic [7:0] b, input logic [3:0] be);
    ram_rw_sel_i     = 1'b1;
    ram_rw_addr_i    = a;
    ram_wr_data_i    = {4{b}};
    ram_wr_byte_en_i = be;
    tick();
    ram_wr_byte_en_i = 4'h0;
  endtask

  task automatic host_rd(input logic [31:0] a);
    ram_rw_sel_i     = 1'b1;
    ram_rw_addr_i    = a;
    ram_wr_byte_en_i = 4'h0;
    tick();
  endtask

  task automatic cpu_st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    ram_rw_sel_i      = 1'b0;
    dram_wr_addr_i    = a;
    dram_wr_data_i    = d;
    dram_wr_byte_en_i = be;
    tick();
    dram_wr_byte_en_i = 4'h0;
  endtask

  task automatic rd_i(input logic [31:0] a);
    iram_rd_addr_i = a;
    #1;
  endtask

  task automatic rd_d(input logic [31:0] a);
    dram_rd_addr_i = a;
    #1;
  endtask

  logic [7:0] prog0 [4];
  logic [7:0] prog1 [4];

  initial begin
    prog0[0] = 8'h93; prog0[1] = 8'h00; prog0[2] = 8'hf0; prog0[3] = 8'h0d;
    prog1[0] = 8'h37; prog1[1] = 8'h01; prog1[2] = 8'h00; prog1[3] = 8'h10;

    rst_n_i           = 1'b0;
    ram_rw_sel_i      = 1'b0;
    ram_rw_addr_i     = 32'h0;
    ram_wr_data_i     = 32'h0;
    ram_wr_byte_en_i  = 4'h0;
    iram_rd_addr_i    = 32'h0;
    dram_rd_addr_i    = 32'h0;
    dram_wr_addr_i    = 32'h0;
    dram_wr_data_i    = 32'h0;
    dram_wr_byte_en_i = 4'h0;
    tick();
    tick();
    check_eq("reset_host_rd", {24'h0, ram_rd_data_o}, 32'h0);
    rst_n_i = 1'b1;

    // Program load through the host byte port.
    for (int i = 0; i < 4; i++) host_wr(32'(i), prog0[i], 4'(1 << i));
    rd_i(32'h0);
    check_eq("load_word0", iram_rd_data_o, 32'h0df00093);
    rd_d(32'h0);
    check_eq("load_word0_dport", dram_rd_data_o, 32'h0df00093);
    for (int i = 0; i < 4; i++) host_wr(32'(4 + i), prog1[i], 4'(1 << i));
    rd_i(32'h4);
    check_eq("load_word1", iram_rd_data_o, 32'h10000137);
    rd_i(32'h6);
    check_eq("load_word1_lowbits", iram_rd_data_o, 32'h10000137);

    // Host byte reads of IRAM.
    host_rd(32'h3);
    check_eq("host_rd_b3", {24'h0, ram_rd_data_o}, 32'h0000000d);
    host_rd(32'h0);
    check_eq("host_rd_b0", {24'h0, ram_rd_data_o}, 32'h00000093);

    // CPU store then host read-back.
    cpu_st(32'h1000_0000, 32'h0000_00df, 4'hf);
    rd_d(32'h1000_0000);
    check_eq("cpu_store", dram_rd_data_o, 32'h000000df);
    host_rd(32'h1000_0000);
    check_eq("host_rd_dram", {24'h0, ram_rd_data_o}, 32'h000000df);

    // Host read-before-write on the same word.
    host_wr(32'h1000_0000, 8'h5a, 4'b0001);
    check_eq("rbw_old_byte", {24'h0, ram_rd_data_o}, 32'h000000df);
    rd_d(32'h1000_0000);
    check_eq("rbw_word", dram_rd_data_o, 32'h0000005a);
    host_rd(32'h1000_0000);
    check_eq("rbw_new_byte", {24'h0, ram_rd_data_o}, 32'h0000005a);

    // Partial enable and zero enable.
    cpu_st(32'h1000_0000, 32'h11223344, 4'hf);
    cpu_st(32'h1000_0000, 32'haabbccdd, 4'b0100);
    rd_d(32'h1000_0000);
    check_eq("partial_be", dram_rd_data_o, 32'h11bb3344);
    cpu_st(32'h1000_0000, 32'hffffffff, 4'h0);
    rd_d(32'h1000_0000);
    check_eq("zero_be", dram_rd_data_o, 32'h11bb3344);

    // Ownership gating.
    cpu_st(32'h1000_0004, 32'hcafef00d, 4'hf);
    ram_rw_sel_i      = 1'b1;
    ram_wr_byte_en_i  = 4'h0;
    dram_wr_addr_i    = 32'h1000_0004;
    dram_wr_data_i    = 32'hffffffff;
    dram_wr_byte_en_i = 4'hf;
    tick();
    dram_wr_byte_en_i = 4'h0;
    rd_d(32'h1000_0004);
    check_eq("gate_cpu", dram_rd_data_o, 32'hcafef00d);
    ram_rw_sel_i     = 1'b0;
    ram_rw_addr_i    = 32'h0;
    ram_wr_data_i    = 32'hffffffff;
    ram_wr_byte_en_i = 4'hf;
    tick();
    ram_wr_byte_en_i = 4'h0;
    rd_i(32'h0);
    check_eq("gate_host", iram_rd_data_o, 32'h0df00093);

    // Decode edges: aliasing and unmapped region.
    cpu_st(32'h1000_0000 + (32'h1 << 12), 32'h600dbeef, 4'hf);
    rd_d(32'h1000_0000);
    check_eq("alias_dram0", dram_rd_data_o, 32'h600dbeef);
    cpu_st(32'h2000_0000, 32'h12345678, 4'hf);
    rd_d(32'h2000_0000);
    check_eq("unmapped_rd", dram_rd_data_o, 32'h0);
    rd_d(32'h1000_0000);
    check_eq("unmapped_no_dram", dram_rd_data_o, 32'h600dbeef);
    rd_i(32'h0);
    check_eq("unmapped_no_iram", iram_rd_data_o, 32'h0df00093);
    host_wr(32'h2000_0001, 8'h77, 4'b0010);
    host_rd(32'h2000_0001);
    check_eq("unmapped_host_rd", {24'h0, ram_rd_data_o}, 32'h0);

    // Reset in the middle of host writes.
    host_rd(32'h3);
    check_eq("pre_reset_rd", {24'h0, ram_rd_data_o}, 32'h0000000d);
    rst_n_i          = 1'b0;
    ram_rw_sel_i     = 1'b1;
    ram_rw_addr_i    = 32'h0000_0003;
    ram_wr_data_i    = 32'hffffffff;
    ram_wr_byte_en_i = 4'hf;
    tick();
    check_eq("rst_host_rd_c1", {24'h0, ram_rd_data_o}, 32'h0);
    tick();
    check_eq("rst_host_rd_c2", {24'h0, ram_rd_data_o}, 32'h0);
    rd_i(32'h0);
    check_eq("rst_iram_kept", iram_rd_data_o, 32'h0df00093);
    ram_wr_byte_en_i = 4'h0;
    rst_n_i          = 1'b1;
    rd_i(32'h4);
    check_eq("post_rst_word1", iram_rd_data_o, 32'h10000137);
    rd_d(32'h1000_0004);
    check_eq("post_rst_dram1", dram_rd_data_o, 32'hcafef00d);
    host_rd(32'h4);
    check_eq("post_rst_host", {24'h0, ram_rd_data_o}, 32'h00000037);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
